ram_initiator: RTL and testbench



---
 rtl/ram_initiator.sv | 143 ++++++++++++++
 tb/tb_ram_initiator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_initiator.sv
// ram_initiator: valid/ready front end for a synchronous single-port RAM with credit-bounded in-order read responses.
// Define RAM_INIT_EN to make INIT sweep every address with INIT_VALUE before entering RUN.
module ram_initiator #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int RD_LAT = 1,
  parameter int RSP_DEPTH = 4,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          ram_ce,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          init_done
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(RSP_DEPTH + RD_LAT + 2) + 1;

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_d;

  logic          accept, push, pop;
  logic          ce_d, wr_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [DW-1:0] fifo_data [RSP_DEPTH];
  logic [AW-1:0] fifo_addr [RSP_DEPTH];
  logic [RD_LAT-1:0] tag_v;
  logic [AW-1:0] tag_a [RD_LAT];

`ifdef RAM_INIT_EN
  logic [AW-1:0] init_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + 1'b1;
  always_comb begin
    state_d = (state == INIT && init_cnt == '1) ? RUN : state;
  end
`else
  always_comb begin
    state_d = RUN;
  end
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= INIT;
    else state <= state_d;

  assign init_done = state == RUN;

  // Credits cover the FIFO plus every read still travelling toward it.
  always_comb begin
    occ = OW'(count) + OW'(ram_ce && !ram_wr);
    for (int i = 0; i < RD_LAT; i++) occ = occ + OW'(tag_v[i]);
  end

  assign req_ready = init_done && occ < OW'(RSP_DEPTH);
  assign accept = req_valid && req_ready;

  always_comb begin
    ce_d = accept;
    wr_d = accept && req_wr;
    addr_d = accept ? req_addr : ram_addr;
    din_d = accept ? req_wdata : ram_din;
`ifdef RAM_INIT_EN
    if (state == INIT) begin
      ce_d = 1'b1;
      wr_d = 1'b1;
      addr_d = init_cnt;
      din_d = INIT_VALUE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ram_ce <= 1'b0;
      ram_wr <= 1'b0;
      ram_addr <= '0;
      ram_din <= '0;
    end else begin
      ram_ce <= ce_d;
      ram_wr <= wr_d;
      ram_addr <= addr_d;
      ram_din <= din_d;
    end

  // Tag pipe tracks reads until ram_dout carries their data.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_a[i] <= '0;
    end else begin
      tag_v[0] <= ram_ce && !ram_wr;
      tag_a[0] <= ram_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end
    end

  assign push = tag_v[RD_LAT-1];
  assign rsp_valid = count != '0;
  assign pop = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end

  always_ff @(posedge clk)
    if (push) begin
      fifo_data[wr_ptr] <= ram_dout;
      fifo_addr[wr_ptr] <= tag_a[RD_LAT-1];
    end

  assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_addr = rsp_valid ? fifo_addr[rd_ptr] : '0;

  assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_ram_initiator.sv
// tb_ram_initiator: directed checks of ram_initiator against a behavioural single-port RAM.
module tb_ram_initiator;
  localparam int AW = 8;
  localparam int DW = 16;
`ifdef RAM_INIT_EN
  localparam int INIT_CYC = 256;
  localparam logic [7:0] POST_ADDR = 8'hFF;
  localparam logic [15:0] POST0 = 16'hA5A5;
  localparam logic [15:0] POST1 = 16'hA5A5;
`else
  localparam int INIT_CYC = 1;
  localparam logic [7:0] POST_ADDR = 8'h05;
  localparam logic [15:0] POST0 = 16'h0100;
  localparam logic [15:0] POST1 = 16'h0105;
`endif

  logic clk, rst, req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
  logic ram_ce, ram_wr, init_done;
  logic [AW-1:0] req_addr, rsp_addr, ram_addr;
  logic [DW-1:0] req_wdata, rsp_data, ram_din, ram_dout;
  logic [DW-1:0] mem [256];
  int checks = 0;
  int fails = 0;

  ram_initiator #(.AW(AW), .DW(DW), .RD_LAT(1), .RSP_DEPTH(4), .INIT_VALUE(16'hA5A5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .ram_ce(ram_ce), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .init_done(init_done));

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_ce) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input logic wr, input logic [7:0] a, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin fails++; $display("FAIL issue_timeout: waited %0d cycles, required < 100", n); end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic test_reset;
    int cyc, bad;
    rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_addr, ram_ce, ram_wr, ram_addr, ram_din, init_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h a=%h ce=%b wr=%b ra=%h din=%h done=%b, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_addr, ram_ce, ram_wr, ram_addr, ram_din, init_done);
    end
    rst = 0;
    cyc = 0; bad = 0;
    while (!init_done && cyc < 1000) begin
      if (req_ready) bad++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== INIT_CYC) begin fails++; $display("FAIL init_length: got %0d cycles, required %0d", cyc, INIT_CYC); end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL ready_during_init: got %0d ready cycles, required 0", bad); end
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_init: got %b, required 1", req_ready); end
  endtask

  task automatic test_write_read;
    rsp_ready = 1;
    issue(1, 8'h00, 16'h0077);
    issue(1, 8'h01, 16'h00EE);
    req_valid = 1; req_wr = 0; req_addr = 8'h00;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL wr_rd_ready: got %b, required 1", req_ready); end
    @(negedge clk);
    req_addr = 8'h01;
    checks++;
    if ({ram_ce, ram_wr, ram_addr, rsp_valid} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++; $display("FAIL rd0_issue: got ce=%b wr=%b a=%h v=%b, required 1 0 00 0", ram_ce, ram_wr, ram_addr, rsp_valid);
    end
    @(negedge clk);
    req_valid = 0;
    checks++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd0_early_valid: got %b, required 0", rsp_valid); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, 16'h0077, 8'h00}) begin
      fails++; $display("FAIL rd0_rsp: got v=%b d=%h a=%h, required 1 0077 00", rsp_valid, rsp_data, rsp_addr);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, 16'h00EE, 8'h01}) begin
      fails++; $display("FAIL rd1_rsp: got v=%b d=%h a=%h, required 1 00ee 01", rsp_valid, rsp_data, rsp_addr);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rd_drain: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_raw;
    rsp_ready = 1;
    req_valid = 1; req_wr = 1; req_addr = 8'h05; req_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_wr, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h05, 16'h1234}) begin
      fails++; $display("FAIL raw_write_issue: got ce=%b wr=%b a=%h din=%h, required 1 1 05 1234", ram_ce, ram_wr, ram_addr, ram_din);
    end
    req_wr = 0;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if ({ram_ce, ram_wr, ram_addr} !== {1'b1, 1'b0, 8'h05}) begin
      fails++; $display("FAIL raw_read_issue: got ce=%b wr=%b a=%h, required 1 0 05", ram_ce, ram_wr, ram_addr);
    end
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_wr, rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL raw_idle: got ce=%b wr=%b v=%b, required 0 0 0", ram_ce, ram_wr, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, 16'h1234, 8'h05}) begin
      fails++; $display("FAIL raw_rsp: got v=%b d=%h a=%h, required 1 1234 05", rsp_valid, rsp_data, rsp_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k, got, cyc;
    logic acc;
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) issue(1, 8'(i), 16'(256 + i));
    rsp_ready = 0;
    k = 0; req_valid = 1; req_wr = 0; req_addr = 0;
    repeat (10) begin
      acc = req_ready;
      @(negedge clk);
      if (acc) begin k++; req_addr = 8'(k); end
    end
    checks++;
    if (k !== 4) begin fails++; $display("FAIL bp_accepted: got %0d, required 4", k); end
    checks++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got %b, required 0", req_ready); end
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, 16'h0100, 8'h00}) begin
      fails++; $display("FAIL bp_head_stable: got v=%b d=%h a=%h, required 1 0100 00", rsp_valid, rsp_data, rsp_addr);
    end
    rsp_ready = 1;
    got = 0; cyc = 0;
    while (got < 6 && cyc < 100) begin
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        checks++;
        if ({rsp_addr, rsp_data} !== {8'(got), 16'(256 + got)}) begin
          fails++; $display("FAIL bp_rsp%0d: got a=%h d=%h, required a=%h d=%h", got, rsp_addr, rsp_data, 8'(got), 16'(256 + got));
        end
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        k++;
        if (k == 6) req_valid = 0;
        else req_addr = 8'(k);
      end
    end
    req_valid = 0;
    checks++;
    if (got !== 6 || k !== 6) begin fails++; $display("FAIL bp_totals: got rsp=%0d acc=%0d, required 6 6", got, k); end
  endtask

  task automatic test_back_to_back;
    int k, got, cyc, gaps;
    logic acc;
    rsp_ready = 0;
    k = 0; req_valid = 1; req_wr = 0; req_addr = 0;
    repeat (6) begin
      acc = req_ready;
      @(negedge clk);
      if (acc) begin k++; req_addr = 8'(k % 6); end
    end
    checks++;
    if (k !== 4 || rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_fill: got acc=%0d v=%b, required 4 1", k, rsp_valid); end
    rsp_ready = 1;
    got = 0; cyc = 0; gaps = 0;
    while (got < 12 && cyc < 100) begin
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        checks++;
        if ({rsp_addr, rsp_data} !== {8'(got % 6), 16'(256 + got % 6)}) begin
          fails++; $display("FAIL b2b_rsp%0d: got a=%h d=%h, required a=%h d=%h", got, rsp_addr, rsp_data, 8'(got % 6), 16'(256 + got % 6));
        end
        got++;
      end else gaps++;
      @(negedge clk);
      cyc++;
      if (acc) begin
        k++;
        if (k == 12) req_valid = 0;
        else req_addr = 8'(k % 6);
      end
    end
    req_valid = 0;
    checks++;
    if (got !== 12 || gaps !== 0) begin fails++; $display("FAIL b2b_stream: got rsp=%0d gaps=%0d, required 12 0", got, gaps); end
  endtask

  task automatic test_reset_inflight;
    int cyc, bad;
    rsp_ready = 1;
    req_valid = 1; req_wr = 0; req_addr = 8'h00;
    @(negedge clk);
    req_addr = 8'h01;
    @(negedge clk);
    req_valid = 0;
    rst = 1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_addr, ram_ce, ram_wr, ram_addr, ram_din, init_done} !== '0) begin
      fails++;
      $display("FAIL rst_inflight_outputs: got rdy=%b v=%b d=%h a=%h ce=%b wr=%b ra=%h din=%h done=%b, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_addr, ram_ce, ram_wr, ram_addr, ram_din, init_done);
    end
    @(negedge clk);
    rst = 0;
    cyc = 0; bad = 0;
    while ((!init_done || cyc < INIT_CYC + 5) && cyc < 1000) begin
      if (rsp_valid) bad++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL rst_stale_rsp: got %0d valid cycles, required 0", bad); end
    checks++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      fails++; $display("FAIL rst_ready_return: got rdy=%b done=%b, required 1 1", req_ready, init_done);
    end
  endtask

  task automatic test_post_reset_read;
    int n;
    rsp_ready = 1;
    issue(0, 8'h00, 16'h0000);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, POST0, 8'h00}) begin
      fails++; $display("FAIL post_rd0: got v=%b d=%h a=%h, required 1 %h 00", rsp_valid, rsp_data, rsp_addr, POST0);
    end
    @(negedge clk);
    issue(0, POST_ADDR, 16'h0000);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, POST1, POST_ADDR}) begin
      fails++; $display("FAIL post_rd1: got v=%b d=%h a=%h, required 1 %h %h", rsp_valid, rsp_data, rsp_addr, POST1, POST_ADDR);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_raw;
    test_backpressure;
    test_back_to_back;
    test_reset_inflight;
    test_post_reset_read;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
